pipe_trace_monitor: RTL and testbench
=====================================

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

Interface
REQ-001 SHALL take parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL take parameter DEPTH, default 8, trace entries; power of 2, >=2.
REQ-003 SHALL take parameter CNT_W, default 32, performance counter width.
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  reset, synchronous, active-low
  arm  in  1  start-capture pulse
  stop  in  1  force-end-capture pulse
  clear  in  1  synchronous soft clear
  trig_en  in  1  wait for trig_pc before capturing
  trig_pc  in  XLEN  trigger PC
  wrap_mode  in  1  1=overwrite oldest when full, 0=stop when full; sampled on arm
  wb_valid  in  1  MEM/WB holds a retiring instruction
  wb_reg_write  in  1  retiring instruction writes rd
  wb_rd  in  5  destination register
  wb_data  in  XLEN  writeback value
  wb_pc  in  XLEN  retiring PC
  stall  in  1  pipeline stall this cycle
  rd_valid  out  1  trace entry available (not empty)
  rd_ready  in  1  consumer pops head entry
  rd_pc/rd_rd/rd_data  out  XLEN/5/XLEN  head entry, first-word-fall-through
  count  out  $clog2(DEPTH)+1  entries held
  overflow  out  1  sticky: entry overwritten unread
  state  out  2  FSM state
  cycle_cnt/retire_cnt/stall_cnt  out  CNT_W each  performance counters

Function
REQ-005 SHALL implement FSM IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
REQ-006 SHALL transition IDLE or DONE -> ARMED on arm with trig_en=1, -> CAPTURE on arm with trig_en=0.
REQ-007 SHALL transition ARMED -> CAPTURE when wb_valid and wb_pc==trig_pc; that writeback SHALL itself be captured.
REQ-008 SHALL transition CAPTURE -> DONE on stop, or on a qualifying writeback arriving while full with wrap_mode=0.
REQ-009 SHALL define qualifying writeback: wb_valid & wb_reg_write & wb_rd!=0 (x0 writes never captured).
REQ-010 SHALL push {wb_pc, wb_rd, wb_data} on a qualifying writeback in CAPTURE; entry visible on rd_* the next cycle (1-cycle latency).
REQ-011 SHALL pop on rd_valid & rd_ready in any state; pop with empty buffer SHALL be ignored.
REQ-012 SHALL, when full and wrap_mode=1, drop the oldest entry, write the new one, keep count=DEPTH, set overflow.
REQ-013 SHALL, when full and wrap_mode=0, drop the new entry and leave contents unchanged.
REQ-014 SHALL, on simultaneous push and pop, keep count unchanged; when full this SHALL NOT set overflow.
REQ-015 SHALL wrap read/write pointers modulo DEPTH.
REQ-016 SHALL increment cycle_cnt every cycle outside IDLE, retire_cnt on wb_valid in CAPTURE, stall_cnt on stall in CAPTURE.
REQ-017 SHALL saturate all counters at 2^CNT_W-1.
REQ-018 SHALL give stop priority over a trigger in the same cycle (ARMED -> DONE directly, nothing captured).

Reset
REQ-019 SHALL on rst_n=0 set state=IDLE, pointers and count=0, overflow=0, counters=0, rd_valid=0; buffer contents undefined.
REQ-020 SHALL treat clear identically to reset, with priority over arm/stop/push/pop in the same cycle.
REQ-021 SHALL discard any in-progress capture on reset mid-operation; no partial entry survives.

Structure
REQ-022 SHALL place state encodings and the trace-entry field widths in shared package pipe_trace_pkg.
REQ-023 SHALL implement storage/pointers in sub-module pipe_trace_fifo (parameters XLEN, DEPTH, wrap flag).

Verification
REQ-024 arm (trig_en=0), 3 writebacks rd=1,2,3 data 5,7,12 -> rd_* returns (1,5),(2,7),(3,12) in order, count 3->0.
REQ-025 trig_en=1, trig_pc=0x10, retire PCs 0x08,0x0C,0x10,0x14 -> capture starts at 0x10; count=2.
REQ-026 DEPTH=8, wrap_mode=1, 10 writebacks, no pops -> count=8, overflow=1, head pc = 3rd retired PC.
REQ-027 wrap_mode=0, 9 writebacks -> count=8, state=DONE, 9th not stored, overflow=0.
REQ-028 writeback rd=0 plus stall for 4 cycles in CAPTURE -> no entry, stall_cnt=4, retire_cnt=1.
REQ-029 reset asserted mid-capture with count=5 -> next cycle state=IDLE, count=0, all counters 0.

Source files
------------

// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace monitor: FSM encoding and entry field widths.
package pipe_trace_pkg;

  localparam int XLEN_DEF = 32;  // default PC / data width
  localparam int RD_W     = 5;   // destination register index width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  // A writeback is worth tracing only if it really updates an architectural register.
  function automatic logic is_qual(input logic v, input logic we, input logic [RD_W-1:0] rd);
    return v & we & (rd != '0);
  endfunction

endpackage

// File: rtl/pipe_trace_fifo.sv
// Trace storage: circular buffer with first-word-fall-through head and optional overwrite-oldest.
module pipe_trace_fifo
  import pipe_trace_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst_i,   // synchronous clear (reset or soft clear)
  input  logic                     wrap_i,   // overwrite oldest when full
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [RD_W-1:0]          rd_i,
  input  logic [XLEN-1:0]          data_i,
  output logic [XLEN-1:0]          pc_o,
  output logic [RD_W-1:0]          rd_o,
  output logic [XLEN-1:0]          data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     ovf_o,
  output logic                     drop_o    // push refused: full, no pop, no wrap
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [RD_W-1:0] rd_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          do_pop, room, wr_en, evict;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees a slot, so a full buffer can still accept without evicting.
  assign room    = ~full_o | do_pop;
  assign wr_en   = push_i & (room | wrap_i);
  assign evict   = push_i & ~room & wrap_i;
  assign drop_o  = push_i & ~room & ~wrap_i;

  // Next-state for pointers, occupancy and the sticky overwrite flag.
  always_comb begin
    wr_d  = wr_q + PW'(wr_en);
    rd_d  = rd_q + PW'(do_pop | evict);
    ovf_d = ovf_q | evict;
    cnt_d = cnt_q;
    if (wr_en && !do_pop && !evict) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !wr_en)      cnt_d = cnt_q - 1'b1;
  end

  // Control state register; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry write port.
  always_ff @(posedge clk) begin
    if (wr_en && !srst_i) begin
      pc_mem[wr_q]   <= pc_i;
      rd_mem[wr_q]   <= rd_i;
      data_mem[wr_q] <= data_i;
    end
  end

  assign pc_o    = pc_mem[rd_q];
  assign rd_o    = rd_mem[rd_q];
  assign data_o  = data_mem[rd_q];
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Retirement trace monitor: optional PC trigger, capture FSM, trace FIFO and perf counters.
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  input  logic                   wrap_mode,
  input  logic                   wb_valid,
  input  logic                   wb_reg_write,
  input  logic [RD_W-1:0]        wb_rd,
  input  logic [XLEN-1:0]        wb_data,
  input  logic [XLEN-1:0]        wb_pc,
  input  logic                   stall,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [XLEN-1:0]        rd_pc,
  output logic [RD_W-1:0]        rd_rd,
  output logic [XLEN-1:0]        rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  trace_state_e     state_q, state_d;
  logic             wrap_q, wrap_d;
  logic             soft_rst, wb_qual, trig_hit, cap_push;
  logic             fifo_empty, fifo_full, fifo_drop;
  logic [CNT_W-1:0] cyc_q, ret_q, stl_q;

  assign soft_rst = ~rst_n | clear;
  assign wb_qual  = is_qual(wb_valid, wb_reg_write, wb_rd);
  assign trig_hit = wb_valid & (wb_pc == trig_pc);

  // Push whenever capturing; the trigger writeback is captured too. Stop wins over both.
  always_comb begin
    cap_push = 1'b0;
    if (!stop) begin
      if (state_q == ST_CAPTURE)                cap_push = wb_qual;
      else if (state_q == ST_ARMED && trig_hit) cap_push = wb_qual;
    end
  end

  // Capture FSM next-state; wrap mode is latched on arm.
  always_comb begin
    state_d = state_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          wrap_d  = wrap_mode;
          state_d = trig_en ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (stop)          state_d = ST_DONE;
        else if (trig_hit) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (stop || fifo_drop) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and wrap-mode registers.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q <= ST_IDLE;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      cyc_q <= '0;
      ret_q <= '0;
      stl_q <= '0;
    end else begin
      if (state_q != ST_IDLE && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
      if (state_q == ST_CAPTURE && wb_valid && ret_q != '1) ret_q <= ret_q + 1'b1;
      if (state_q == ST_CAPTURE && stall && stl_q != '1) stl_q <= stl_q + 1'b1;
    end
  end

  pipe_trace_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .srst_i  (soft_rst),
    .wrap_i  (wrap_q),
    .push_i  (cap_push),
    .pop_i   (rd_ready),
    .pc_i    (wb_pc),
    .rd_i    (wb_rd),
    .data_i  (wb_data),
    .pc_o    (rd_pc),
    .rd_o    (rd_rd),
    .data_o  (rd_data),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .ovf_o   (overflow),
    .drop_o  (fifo_drop)
  );

  assign rd_valid   = ~fifo_empty;
  assign state      = state_q;
  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
  assign stall_cnt  = stl_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Bench for pipe_trace_monitor: directed scenarios plus randomized run against a queue model.
module tb_pipe_trace_monitor;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, arm, stop, clear, trig_en, wrap_mode;
  logic [XLEN-1:0] trig_pc, wb_data, wb_pc;
  logic wb_valid, wb_reg_write, stall, rd_ready;
  logic [4:0] wb_rd;
  logic rd_valid;
  logic [XLEN-1:0] rd_pc, rd_data;
  logic [4:0] rd_rd;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic [1:0] state;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .stop(stop), .clear(clear),
    .trig_en(trig_en), .trig_pc(trig_pc), .wrap_mode(wrap_mode),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .stall(stall),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_rd(rd_rd),
    .rd_data(rd_data), .count(count), .overflow(overflow), .state(state),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [XLEN-1:0] pc; logic [4:0] rd; logic [XLEN-1:0] data; } ent_t;
  ent_t m_q[$];
  int   m_st   = 0;   // 0 idle, 1 armed, 2 capture, 3 done
  bit   m_wrap = 0;
  bit   m_ovf  = 0;
  int   m_cyc  = 0, m_ret = 0, m_stl = 0;

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit   pop, qual, hit, push;
    int   nst;
    ent_t e;
    if (!rst_n || clear) begin
      m_q.delete(); m_st = 0; m_wrap = 0; m_ovf = 0; m_cyc = 0; m_ret = 0; m_stl = 0;
      return;
    end
    pop  = rd_ready && (m_q.size() > 0);
    qual = wb_valid && wb_reg_write && (wb_rd != 0);
    hit  = wb_valid && (wb_pc == trig_pc);
    push = 0;
    nst  = m_st;
    if (m_st != 0 && m_cyc < CMAX) m_cyc++;
    if (m_st == 2 && wb_valid && m_ret < CMAX) m_ret++;
    if (m_st == 2 && stall && m_stl < CMAX) m_stl++;
    case (m_st)
      0, 3: if (arm) begin m_wrap = wrap_mode; nst = trig_en ? 1 : 2; end
      1: if (stop) nst = 3; else if (hit) begin nst = 2; push = qual; end
      default: if (stop) nst = 3; else push = qual;
    endcase
    if (pop) void'(m_q.pop_front());
    if (push) begin
      e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data;
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else if (m_wrap) begin void'(m_q.pop_front()); m_q.push_back(e); m_ovf = 1; end
      else if (m_st == 2) nst = 3;
    end
    m_st = nst;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; stop = 0; clear = 0; trig_en = 0; trig_pc = '0; wrap_mode = 0;
    wb_valid = 0; wb_reg_write = 0; wb_rd = '0; wb_data = '0; wb_pc = '0;
    stall = 0; rd_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic set_wb(input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic [XLEN-1:0] data);
    wb_valid = 1; wb_reg_write = 1; wb_pc = pc; wb_rd = rd; wb_data = data;
  endtask

  task automatic do_arm(input bit te, input logic [XLEN-1:0] tpc, input bit wm);
    arm = 1; trig_en = te; trig_pc = tpc; wrap_mode = wm;
    tick();
    arm = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b want 0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    checks++; if (cycle_cnt !== '0) begin errors++; $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); end
  endtask

  task automatic test_basic_order();
    logic [XLEN-1:0] dat [3];
    dat[0] = 5; dat[1] = 7; dat[2] = 12;
    do_reset();
    do_arm(0, '0, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_state: got %0d want 2", state); end
    for (int i = 0; i < 3; i++) begin
      set_wb(32'h100 + 4 * i, 5'(i + 1), dat[i]);
      tick();
      if (i == 0) begin
        checks++; if (rd_valid !== 1'b1 || rd_rd !== 5'd1) begin
          errors++; $display("FAIL basic_latency: got v=%0b rd=%0d want v=1 rd=1", rd_valid, rd_rd);
        end
      end
    end
    wb_valid = 0;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL basic_count3: got %0d want 3", count); end
    rd_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_rd !== 5'(i + 1) || rd_data !== dat[i]) begin
        errors++; $display("FAIL basic_pop%0d: got v=%0b rd=%0d d=%0d want v=1 rd=%0d d=%0d",
                           i, rd_valid, rd_rd, rd_data, i + 1, dat[i]);
      end
      tick();
    end
    rd_ready = 0;
    checks++; if (count !== '0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drained: got count=%0d v=%0b want 0 0", count, rd_valid);
    end
  endtask

  task automatic test_trigger();
    logic [XLEN-1:0] pcs [4];
    pcs[0] = 32'h08; pcs[1] = 32'h0C; pcs[2] = 32'h10; pcs[3] = 32'h14;
    do_reset();
    do_arm(1, 32'h10, 0);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL trig_armed: got %0d want 1", state); end
    for (int i = 0; i < 4; i++) begin set_wb(pcs[i], 5'd5, pcs[i]); tick(); end
    wb_valid = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL trig_state: got %0d want 2", state); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL trig_count: got %0d want 2", count); end
    checks++; if (rd_pc !== 32'h10) begin errors++; $display("FAIL trig_head: got %0h want 10", rd_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    do_arm(0, '0, 1);
    for (int i = 0; i < 10; i++) begin set_wb(32'h200 + 4 * i, 5'd3, i); tick(); end
    wb_valid = 0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_count: got %0d want 8", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_overflow: got %0b want 1", overflow); end
    checks++; if (rd_pc !== 32'h208) begin errors++; $display("FAIL wrap_head: got %0h want 208", rd_pc); end
  endtask

  task automatic test_nowrap_full();
    do_reset();
    do_arm(0, '0, 0);
    for (int i = 0; i < 9; i++) begin set_wb(32'h300 + 4 * i, 5'd4, i); tick(); end
    wb_valid = 0;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL nowrap_count: got %0d want 8", count); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL nowrap_state: got %0d want 3", state); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL nowrap_overflow: got %0b want 0", overflow); end
    rd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (rd_pc !== 32'h300 + 4 * i) begin
        errors++; $display("FAIL nowrap_entry%0d: got %0h want %0h", i, rd_pc, 32'h300 + 4 * i);
      end
      tick();
    end
    rd_ready = 0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL nowrap_ninth: got v=%0b want 0", rd_valid); end
  endtask

  task automatic test_x0_stall();
    do_reset();
    do_arm(0, '0, 0);
    set_wb(32'h40, 5'd0, 32'hDEAD);
    stall = 1;
    tick();
    wb_valid = 0;
    repeat (3) tick();
    stall = 0;
    checks++; if (count !== '0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL x0_entry: got count=%0d v=%0b want 0 0", count, rd_valid);
    end
    checks++; if (stall_cnt !== 8'd4) begin errors++; $display("FAIL x0_stall_cnt: got %0d want 4", stall_cnt); end
    checks++; if (retire_cnt !== 8'd1) begin errors++; $display("FAIL x0_retire_cnt: got %0d want 1", retire_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_arm(0, '0, 0);
    for (int i = 0; i < 5; i++) begin set_wb(32'h500 + 4 * i, 5'd6, i); stall = 1; tick(); end
    wb_valid = 0; stall = 0;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_count5: got %0d want 5", count); end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got st=%0d count=%0d v=%0b want 0 0 0", state, count, rd_valid);
    end
    checks++; if (cycle_cnt !== '0 || retire_cnt !== '0 || stall_cnt !== '0) begin
      errors++; $display("FAIL mid_counters: got %0d %0d %0d want 0 0 0", cycle_cnt, retire_cnt, stall_cnt);
    end
  endtask

  task automatic test_stop_priority();
    do_reset();
    do_arm(1, 32'h40, 0);
    set_wb(32'h40, 5'd3, 32'h77);
    stop = 1;
    tick();
    stop = 0; wb_valid = 0;
    checks++; if (state !== 2'd3 || count !== '0) begin
      errors++; $display("FAIL stop_prio: got st=%0d count=%0d want 3 0", state, count);
    end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    do_arm(0, '0, 1);
    for (int i = 0; i < 8; i++) begin set_wb(32'h600 + 4 * i, 5'd2, i); tick(); end
    set_wb(32'h700, 5'd2, 99);
    rd_ready = 1;
    tick();
    rd_ready = 0; wb_valid = 0;
    checks++; if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++; $display("FAIL pushpop_full: got count=%0d ovf=%0b want 8 0", count, overflow);
    end
    checks++; if (rd_pc !== 32'h604) begin errors++; $display("FAIL pushpop_head: got %0h want 604", rd_pc); end
    // soft clear beats arm and a push in the same cycle
    clear = 1; arm = 1;
    set_wb(32'h800, 5'd2, 1);
    tick();
    clear = 0; arm = 0; wb_valid = 0;
    checks++; if (state !== 2'd0 || count !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clear_prio: got st=%0d count=%0d ovf=%0b want 0 0 0", state, count, overflow);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    do_arm(1, 32'hFFFF_FFF0, 0);
    repeat (300) tick();
    checks++; if (cycle_cnt !== 8'(CMAX)) begin
      errors++; $display("FAIL sat_cycle_cnt: got %0d want %0d", cycle_cnt, CMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      arm          = ($urandom_range(0, 19) == 0);
      stop         = ($urandom_range(0, 59) == 0);
      clear        = ($urandom_range(0, 299) == 0);
      trig_en      = $urandom_range(0, 1);
      wrap_mode    = $urandom_range(0, 1);
      trig_pc      = 32'h20;
      wb_valid     = ($urandom_range(0, 3) != 0);
      wb_reg_write = ($urandom_range(0, 3) != 0);
      wb_rd        = 5'($urandom_range(0, 3));
      wb_data      = $urandom;
      wb_pc        = 32'h10 + 4 * $urandom_range(0, 7);
      stall        = $urandom_range(0, 1);
      rd_ready     = ($urandom_range(0, 2) == 0);
      tick();
      checks++; if (state !== 2'(m_st)) begin errors++; $display("FAIL rnd_state c%0d: got %0d want %0d", c, state, m_st); end
      checks++; if (count !== 4'(m_q.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, m_q.size()); end
      checks++; if (rd_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, rd_valid, m_q.size() > 0); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf c%0d: got %0b want %0b", c, overflow, m_ovf); end
      checks++; if (cycle_cnt !== 8'(m_cyc) || retire_cnt !== 8'(m_ret) || stall_cnt !== 8'(m_stl)) begin
        errors++; $display("FAIL rnd_cnts c%0d: got %0d %0d %0d want %0d %0d %0d", c,
                           cycle_cnt, retire_cnt, stall_cnt, m_cyc, m_ret, m_stl);
      end
      if (m_q.size() > 0) begin
        checks++; if (rd_pc !== m_q[0].pc || rd_rd !== m_q[0].rd || rd_data !== m_q[0].data) begin
          errors++; $display("FAIL rnd_head c%0d: got %0h/%0d/%0h want %0h/%0d/%0h", c,
                             rd_pc, rd_rd, rd_data, m_q[0].pc, m_q[0].rd, m_q[0].data);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_basic_order();
    test_trigger();
    test_wrap();
    test_nowrap_full();
    test_x0_stall();
    test_reset_mid();
    test_stop_priority();
    test_push_pop_full();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
